alu_flag_branch_unit: RTL
=========================

Name: alu_flag_branch_unit

Overview:
- Consumes the CO/OVF/Z/N flags produced by the ALU.
- Holds them in an architectural status register and evaluates 4-bit branch conditions against them.
- Forwards taken-branch targets to the PC unit over a valid/ready handshake.
- Sits between the ALU, the instruction decoder (branch requests) and the PC register.

Parameters:
- W, 4, address/target width; matches the ALU datapath width.
- CNT_W, 8, width of the saturating taken-branch counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_co  in  1  ALU carry-out (borrow bit for subtract ops).
- alu_ovf  in  1  ALU signed overflow.
- alu_z  in  1  ALU zero flag.
- alu_n  in  1  ALU negative flag.
- flag_we  in  1  capture ALU flags into the status register this cycle.
- flag_restore  in  1  load the status register from flag_wdata.
- flag_wdata  in  4  restore value {N,Z,C,V}.
- flags  out  4  current status register {N,Z,C,V}.
- br_valid  in  1  decoder presents a branch request.
- br_ready  out  1  unit can accept a branch request.
- br_cond  in  4  condition code.
- br_target  in  W  branch target address.
- br_not_taken  out  1  one-cycle pulse: accepted branch evaluated false.
- pc_valid  out  1  taken-branch target available.
- pc_ready  in  1  PC unit accepts the target.
- pc_target  out  W  registered branch target.
- taken_cnt  out  CNT_W  saturating count of taken branches.

Behaviour:
- Reset (synchronous, active-high): flags=0, br_ready=1, br_not_taken=0, pc_valid=0, pc_target=0, taken_cnt=0, FSM=IDLE. Reset mid-ISSUE drops the pending target; no pc handshake completes.
- Status register update priority: reset > flag_restore > flag_we > hold.
- Effective flags for evaluation: when flag_we=1 and flag_restore=0 in the acceptance cycle, use the live ALU inputs (forwarding). When flag_restore=1, use flag_wdata. Otherwise use the registered flags.
- Condition codes (C is the raw ALU CO bit):
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: !C & !Z. 9 LS: C | Z.
  - A GE: N==V. B LT: N!=V. C GT: !Z & (N==V). D LE: Z | (N!=V).
  - E AL: 1. F NV: 0.
- Branch acceptance happens when br_valid & br_ready.
- FSM states IDLE and ISSUE:
  - IDLE: br_ready=1.
    - On acceptance with condition true: latch pc_target <= br_target, pc_valid=1 next cycle, go to ISSUE, taken_cnt += 1, saturating at all-ones.
    - On acceptance with condition false: br_not_taken=1 for exactly the next cycle, stay in IDLE. Back-to-back requests are allowed.
  - ISSUE: br_ready=0, pc_valid=1, pc_target stable. On pc_ready=1, return to IDLE next cycle with pc_valid=0.
- Latency: request to pc_valid is 1 cycle. pc_ready is sampled only in ISSUE; pc_ready asserted in IDLE has no effect.
- flag_we and flag_restore stay fully functional in ISSUE. A held target is never re-evaluated.
- br_cond and br_target are ignored when no acceptance occurs.

Decomposition:
- Shared package holds:
  - Condition-code constants COND_EQ..COND_NV (4-bit).
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FSM state encodings ST_IDLE and ST_ISSUE.
- One combinational sub-module, cond_eval (inputs: flags[3:0] and cond[3:0]; output: take), reused later by conditional-execute logic.

Test Plan:
- Reset and flag capture: assert reset 2 cycles -> flags=0000, br_ready=1, pc_valid=0, taken_cnt=0. Then flag_we=1 with co=1,ovf=0,z=1,n=0 -> flags=0110 next cycle.
- Forwarding: registered flags=0000, same cycle flag_we=1 with z=1, br_valid=1, cond=EQ, target=0xA -> pc_valid=1, pc_target=0xA next cycle, taken_cnt=1.
- Not taken and back-to-back: flags Z=0, cond=EQ on two consecutive cycles -> br_not_taken high for 2 cycles, pc_valid stays 0, br_ready stays 1.
- Handshake stall: taken AL branch with target=0x5 and pc_ready=0 for 3 cycles -> pc_valid=1, pc_target=0x5 and br_ready=0 held for those cycles. pc_ready=1 -> IDLE next cycle with pc_valid=0. A new br_valid during the stall is not accepted.
- Signed conditions: flags N=1,V=0 -> GE false, LT true, LE true. flags N=1,V=1,Z=0 -> GT true.
- Priority, saturation and reset: flag_restore=1 with wdata=1001 together with flag_we=1 -> flags=1001. 300 taken branches with CNT_W=8 -> taken_cnt=255. Reset during ISSUE -> pc_valid=0 next cycle.

Source files
------------

// File: rtl/alu_flag_branch_unit_pkg.sv
// alu_flag_branch_unit_pkg: condition codes, flag bit indices and FSM states shared by the branch unit
package alu_flag_branch_unit_pkg;
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;
endpackage

// File: rtl/alu_flag_branch_unit_cond_eval.sv
// cond_eval: evaluates a 4-bit condition code against {N,Z,C,V}
module cond_eval
  import alu_flag_branch_unit_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       take
);
  logic n, z, c, v, base;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  // Codes come in pairs where the odd code is the inverse of the even one
  always_comb begin
    base = 1'b1;
    case (cond & 4'hE)
      COND_EQ: base = z;
      COND_CS: base = c;
      COND_MI: base = n;
      COND_VS: base = v;
      COND_HI: base = !c && !z;
      COND_GE: base = n == v;
      COND_GT: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    take = base ^ cond[0];
  end
endmodule

// File: rtl/alu_flag_branch_unit.sv
// alu_flag_branch_unit: status register, branch condition evaluation and taken-target handshake to the PC
module alu_flag_branch_unit
  import alu_flag_branch_unit_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_co,
  input  logic             alu_ovf,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             flag_we,
  input  logic             flag_restore,
  input  logic [3:0]       flag_wdata,
  output logic [3:0]       flags,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [3:0]       br_cond,
  input  logic [W-1:0]     br_target,
  output logic             br_not_taken,
  output logic             pc_valid,
  input  logic             pc_ready,
  output logic [W-1:0]     pc_target,
  output logic [CNT_W-1:0] taken_cnt
);
  state_t     state;
  logic [3:0] eff_flags;
  logic       take, accept;
  // Next status value doubles as the forwarded flags for this cycle's branch
  assign eff_flags = flag_restore ? flag_wdata :
                     flag_we ? {alu_n, alu_z, alu_co, alu_ovf} : flags;
  assign accept = br_valid && br_ready;
  cond_eval u_cond_eval (
    .flags(eff_flags),
    .cond (br_cond),
    .take (take)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      flags        <= '0;
      br_ready     <= 1'b1;
      br_not_taken <= 1'b0;
      pc_valid     <= 1'b0;
      pc_target    <= '0;
      taken_cnt    <= '0;
    end else begin
      flags        <= eff_flags;
      br_not_taken <= accept && !take;
      case (state)
        ST_IDLE: if (accept && take) begin
          state     <= ST_ISSUE;
          br_ready  <= 1'b0;
          pc_valid  <= 1'b1;
          pc_target <= br_target;
          taken_cnt <= taken_cnt + CNT_W'(taken_cnt != '1);
        end
        ST_ISSUE: if (pc_ready) begin
          state    <= ST_IDLE;
          br_ready <= 1'b1;
          pc_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
